// File: rtl/dipsw_irq_pkg.sv
// Shared constants for the DIP-switch/pushbutton interrupt controller:
// register word addresses and the per-bit debounce state encoding.
package dipsw_irq_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_RAW     = 2'd3;

  typedef enum logic {
    ST_STABLE,
    ST_COUNTING
  } deb_state_e;

endpackage

// File: rtl/dipsw_debounce_bit.sv
// One input bit: 2-flop synchroniser, debounce counter/FSM and
// single-cycle rising/falling pulses on each accepted level change.
module dipsw_debounce_bit
  import dipsw_irq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic sync_o,
  output logic deb_o,
  output logic edge_rise_o,
  output logic edge_fall_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  deb_state_e       state_q, state_d;
  logic             differ, accept;

  assign differ = (sync2_q != deb_q);
  assign accept = (state_q == ST_COUNTING) && differ && (cnt_q == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      state_q <= ST_STABLE;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    unique case (state_q)
      ST_STABLE: begin
        if (differ) begin
          state_d = ST_COUNTING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      ST_COUNTING: begin
        if (!differ) begin
          // Input fell back to the accepted level: glitch rejected.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          deb_d   = sync2_q;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    sync_o      = sync2_q;
    deb_o       = deb_q;
    edge_rise_o = accept & sync2_q;
    edge_fall_o = accept & ~sync2_q;
  end

endmodule

// File: rtl/dipsw_irq_ctrl.sv
// Avalon-MM debounced switch/button controller with sticky edge capture and
// maskable level irq. Define DIPSW_ANY_EDGE_EN to capture falling edges too.
module dipsw_irq_ctrl
  import dipsw_irq_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

`ifdef DIPSW_ANY_EDGE_EN
  localparam bit AnyEdge = 1'b1;
`else
  localparam bit AnyEdge = 1'b0;
`endif

  logic [WIDTH-1:0] sync, deb, rise, fall;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d, cap_set, cap_clr;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr;
  logic             unused_wdata;

  for (genvar g = 0; g < WIDTH; g++) begin : gen_bit
    dipsw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .in_i       (in_port[g]),
      .sync_o     (sync[g]),
      .deb_o      (deb[g]),
      .edge_rise_o(rise[g]),
      .edge_fall_o(fall[g])
    );
  end

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_comb begin
    mask_d = mask_q;
    if (wr && address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
    cap_clr = (wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    cap_set = rise | (fall & {WIDTH{AnyEdge}});
    // OR-ing the set term last makes a same-cycle set override the clear.
    cap_d   = (cap_q & ~cap_clr) | cap_set;
  end

  always_comb begin
    readdata_d = '0;
    unique case (address)
      ADDR_DATA:    readdata_d = 32'(deb);
      ADDR_IRQMASK: readdata_d = 32'(mask_q);
      ADDR_EDGECAP: readdata_d = 32'(cap_q);
      ADDR_RAW:     readdata_d = 32'(sync);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      cap_q      <= '0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_dipsw_irq_ctrl.sv
// Bench for dipsw_irq_ctrl: directed vector table, reset corner case, then
// randomized bus/input traffic against a behavioural model.
module tb_dipsw_irq_ctrl;

  localparam int W = 4;
  localparam int D = 4;

`ifdef DIPSW_ANY_EDGE_EN
  localparam bit AnyEdge = 1'b1;
`else
  localparam bit AnyEdge = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dipsw_irq_ctrl #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  // Reference model: a level is accepted once D consecutive synchronised
  // samples disagree with the currently accepted level.
  logic [W-1:0] m_s1, m_s2, m_deb, m_mask, m_cap;
  int           m_run [W];
  logic [31:0]  m_rd;

  always @(posedge clk or negedge reset_n) begin : model
    logic [31:0]  rd;
    logic [W-1:0] set, clr;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_cap = '0; m_rd = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      case (address)
        2'd0:    rd = 32'(m_deb);
        2'd1:    rd = 32'(m_mask);
        2'd2:    rd = 32'(m_cap);
        default: rd = 32'(m_s2);
      endcase
      set = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_deb[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i] || AnyEdge) set[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      clr = (chipselect && !write_n && address == 2'd2) ? writedata[W-1:0] : '0;
      if (chipselect && !write_n && address == 2'd1) m_mask = writedata[W-1:0];
      m_cap = (m_cap & ~clr) | set;
      m_s2  = m_s1;
      m_s1  = in_port;
      m_rd  = rd;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step(input logic [W-1:0] din, input logic [1:0] a, input bit wr,
                      input logic [31:0] wd);
    in_port    = din;
    address    = a;
    chipselect = 1'b1;
    write_n    = ~wr;
    writedata  = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic [1:0]   addr;
    bit           wr;
    logic [31:0]  wd;
    logic [31:0]  exp_rd;
    bit           exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [W-1:0] din, logic [1:0] a, bit wr, logic [31:0] wd,
                              logic [31:0] exp_rd, bit exp_irq);
    vec_t v;
    v.din = din; v.addr = a; v.wr = wr; v.wd = wd; v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    tbl.push_back(v);
  endfunction

  initial begin
    int hold;
    logic [W-1:0] cur;

    // Reset-state reads, then 0000->0101 with exact debounce latency.
    for (int a = 0; a < 4; a++) add(4'h0, 2'(a), 0, 0, 0, 0);
    add(4'h5, 0, 0, 0, 0, 0);
    add(4'h5, 3, 0, 0, 0, 0);
    add(4'h5, 3, 0, 0, 5, 0);
    add(4'h5, 0, 0, 0, 0, 0);
    add(4'h5, 0, 0, 0, 0, 0);
    add(4'h5, 0, 0, 0, 0, 0);
    add(4'h5, 0, 0, 0, 5, 0);
    add(4'h5, 2, 0, 0, 5, 0);
    // Mask bit 0, then clear EDGECAP bit 0.
    add(4'h5, 1, 1, 1, 0, 1);
    add(4'h5, 1, 0, 0, 1, 1);
    add(4'h5, 2, 1, 1, 5, 0);
    add(4'h5, 2, 0, 0, 4, 0);
    // 3-cycle glitch on bit 1.
    add(4'h7, 0, 0, 0, 5, 0);
    add(4'h7, 2, 0, 0, 4, 0);
    add(4'h7, 3, 0, 0, 7, 0);
    add(4'h5, 2, 0, 0, 4, 0);
    for (int k = 0; k < 5; k++) add(4'h5, 2'((k % 2) * 2), 0, 0, (k % 2) ? 4 : 5, 0);
    // Bit 2 falls; EDGECAP clear lands on the acceptance cycle.
    for (int k = 0; k < 5; k++) add(4'h1, 0, 0, 0, 5, 0);
    add(4'h1, 2, 1, 4, 4, 0);
    add(4'h1, 2, 0, 0, AnyEdge ? 4 : 0, 0);
    add(4'h1, 0, 0, 0, 1, 0);

    reset_n = 1'b0; in_port = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    repeat (2) @(negedge clk);
    chk("reset_readdata", readdata, 0);
    chk("reset_irq", 32'(irq), 0);
    reset_n = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].din, tbl[k].addr, tbl[k].wr, tbl[k].wd);
      chk($sformatf("vec%0d_readdata", k), readdata, tbl[k].exp_rd);
      chk($sformatf("vec%0d_irq", k), 32'(irq), 32'(tbl[k].exp_irq));
    end

    // Reset while bit 3 is mid-count (cnt=2), then full re-debounce.
    for (int k = 0; k < 4; k++) begin
      step(4'h9, 0, 0, 0);
      chk("midcount_data", readdata, 1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_readdata", readdata, 0);
    chk("async_reset_irq", 32'(irq), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(4'h9, 3, 0, 0); chk("rel_raw", readdata, 0);
    step(4'h9, 2, 0, 0); chk("rel_edgecap", readdata, 0);
    step(4'h9, 1, 0, 0); chk("rel_mask", readdata, 0);
    step(4'h9, 0, 0, 0); chk("rel_data0", readdata, 0);
    step(4'h9, 0, 0, 0); chk("rel_data1", readdata, 0);
    step(4'h9, 0, 0, 0); chk("rel_data2", readdata, 0);
    step(4'h9, 0, 0, 0); chk("rel_data3", readdata, 9);
    step(4'h9, 2, 0, 0); chk("rel_edgecap_set", readdata, 9);
    chk("rel_irq", 32'(irq), 0);

    // Randomized traffic against the model.
    hold = 0;
    cur  = 4'h9;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        cur  = W'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      in_port    = cur;
      address    = 2'($urandom);
      chipselect = 1'($urandom);
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      if (c == 1500) begin
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk("rand_readdata", readdata, m_rd);
      chk("rand_irq", 32'(irq), 32'(|(m_cap & m_mask)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dipsw_irq_ctrl.md
Name: dipsw_irq_ctrl

Overview:
- Avalon-MM slave controller for the board DIP-switch/pushbutton inputs.
- Synchronises and debounces each input bit, captures edges into a sticky register, and raises a maskable level interrupt to the Nios/Qsys interrupt controller.
- Replaces polling of the raw input PIO; sits on the same low-speed peripheral bus segment.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (1 ms at 50 MHz); must be >= 2.
- CNT_W, 16, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- address  in  2  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous switch inputs.
- irq  out  1  level interrupt, active high.

Interface (already decided):
- One clock, clk.
- reset_n is asynchronous, active-low.
- All flops clear on reset_n low regardless of clk.

Behaviour:
- Register map (word addresses):
  - 0 DATA: debounced levels, read-only.
  - 1 IRQMASK: R/W, bits [WIDTH-1:0].
  - 2 EDGECAP: read; write-1-to-clear per bit.
  - 3 RAW: 2-FF-synchronised in_port, read-only.
  - Unused upper bits read 0. Writes to addresses 0 and 3 are ignored.
- readdata:
  - Reloaded every clk with the mux of the current address, independent of chipselect.
  - Read latency is 1 cycle.
  - Reset value 0.
- Synchroniser: 2 flops per bit, reset to 0. RAW therefore lags in_port by 2 cycles.
- Per-bit debounce FSM:
  - STABLE: sync == deb, cnt = 0. On sync != deb, go to COUNTING with cnt = 1.
  - COUNTING: if sync == deb, return to STABLE with cnt = 0 (glitch rejected). Otherwise cnt++.
  - Acceptance: when cnt == DEBOUNCE_CYCLES-1 and sync != deb, set deb <= sync, cnt = 0, return to STABLE, and emit a 1-cycle edge pulse.
  - Total latency from an in_port change to DATA update is 2 + DEBOUNCE_CYCLES clk cycles.
- Edge capture:
  - EDGECAP[i] sets on a rising edge pulse of deb[i].
  - It clears only on a write to address 2 with writedata[i] = 1.
  - If a set and a clear hit the same cycle, set wins (bit stays 1).
- irq = |(EDGECAP & IRQMASK), driven from registers with no combinational path from the bus. Reset value 0.
- Reset behaviour:
  - deb, cnt, EDGECAP and IRQMASK all clear to 0.
  - Inputs already high when reset releases debounce to 1 and set EDGECAP. irq stays low because IRQMASK = 0.
  - Reset mid-count discards the count.
- A write to IRQMASK takes effect on irq in the cycle after the write.

Optional Feature:
- Macro DIPSW_ANY_EDGE_EN.
  - Defined: EDGECAP[i] sets on both rising and falling edge pulses of deb[i].
  - Undefined: rising edges only; falling transitions update DATA but never set EDGECAP.
- The register map is identical in both builds.

Decomposition:
- Package dipsw_irq_pkg:
  - Address constants ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=2, ADDR_RAW=3.
  - Debounce state enum {ST_STABLE, ST_COUNTING}.
- Sub-module dipsw_debounce_bit:
  - One instance per bit, generated WIDTH times.
  - Contains the synchroniser, counter and FSM.
  - Outputs sync, deb and edge_rise/edge_fall pulses.
  - Top level holds the registers, bus mux and irq.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=4):
- Reset release with in_port=4'b0000, then read addresses 0..3 -> readdata=0 each, one cycle after address; irq=0.
- in_port goes 4'b0000->4'b0101 and is held -> DATA=0x5 exactly 6 cycles after the change; EDGECAP=0x5; irq=0 (mask 0).
- Write IRQMASK=0x1 -> irq=1 the next cycle. Write EDGECAP=0x1 -> irq=0 next cycle, EDGECAP=0x4.
- in_port[1] pulses high for 3 cycles, then low -> DATA[1] stays 0, EDGECAP[1] stays 0 (glitch rejected).
- Hold in_port[2] 1->0 and time a write EDGECAP=0x4 to land on the edge-pulse cycle:
  - Without DIPSW_ANY_EDGE_EN: EDGECAP[2]=0.
  - With the macro: EDGECAP[2]=1 (set wins).
- Assert reset_n mid-count (cnt=2) on bit 3 -> all registers read 0 after release; bit 3 re-debounces the full 6 cycles.
